// File: rtl/flex_updown_counter.sv
// Up/down counter with programmable rollover, synchronous load/clear
// and a saturating count of wrap events.
module flex_updown_counter #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int NUM_WRAP_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic                     count_enable,
    input  logic                     count_dir,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic [NUM_WRAP_BITS-1:0] wrap_count
);

    localparam logic [NUM_CNT_BITS-1:0]  CNT_ZERO  = '0;
    localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE   = 1;
    localparam logic [NUM_WRAP_BITS-1:0] WRAP_ONE  = 1;
    localparam logic [NUM_WRAP_BITS-1:0] WRAP_FULL = '1;

    logic [NUM_CNT_BITS-1:0] count_next;
    logic [NUM_CNT_BITS-1:0] terminal;
    logic                    flag_next;
    logic                    wrap_evt;

    assign terminal = count_dir ? rollover_val : CNT_ONE;

    always_comb begin
        count_next = count_out;
        flag_next  = rollover_flag;
        wrap_evt   = 1'b0;
        if (clear) begin
            count_next = CNT_ZERO;
            flag_next  = 1'b0;
        end else if (load) begin
            count_next = load_val;
            flag_next  = (load_val == terminal);
        end else if (count_enable) begin
            // A zero rollover value freezes the count entirely
            if (rollover_val == CNT_ZERO) begin
                flag_next = 1'b0;
            end else begin
                if (count_dir) begin
                    if (count_out < rollover_val) begin
                        count_next = count_out + CNT_ONE;
                    end else begin
                        count_next = CNT_ONE;
                        wrap_evt   = 1'b1;
                    end
                end else begin
                    if (count_out > CNT_ONE) begin
                        count_next = count_out - CNT_ONE;
                    end else begin
                        count_next = rollover_val;
                        wrap_evt   = 1'b1;
                    end
                end
                flag_next = (count_next == terminal);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            wrap_count    <= '0;
        end else begin
            count_out     <= count_next;
            rollover_flag <= flag_next;
            if (clear) begin
                wrap_count <= '0;
            end else if (wrap_evt && (wrap_count != WRAP_FULL)) begin
                wrap_count <= wrap_count + WRAP_ONE;
            end
        end
    end

endmodule

// File: tb/tb_flex_updown_counter.sv
// Scoreboard bench for flex_updown_counter: directed vectors queue their
// expected outputs; a monitor compares after every rising edge.
module tb_flex_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       count_enable = 1'b0;
    logic       count_dir = 1'b1;
    logic [3:0] rollover_val = '0;
    logic [3:0] count_out;
    logic       rollover_flag;
    logic [1:0] wrap_count;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] c;
        logic       f;
        logic [1:0] w;
        string      name;
    } exp_t;

    exp_t sb[$];

    flex_updown_counter #(
        .NUM_CNT_BITS (4),
        .NUM_WRAP_BITS(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .count_dir    (count_dir),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .wrap_count   (wrap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] c,
                       input logic f, input logic [1:0] w);
        total++;
        if (count_out !== c || rollover_flag !== f || wrap_count !== w) begin
            bad++;
            $display("FAIL %s: got cnt=%0d flag=%0b wrap=%0d want cnt=%0d flag=%0b wrap=%0d",
                     name, count_out, rollover_flag, wrap_count, c, f, w);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the
    // outputs expected after the following rising edge.
    task automatic step(input logic r, input logic cl, input logic ld,
                        input int lv, input logic en, input logic dir,
                        input int rv, input int ec, input logic ef,
                        input int ew, input string name);
        exp_t e;
        @(negedge clk);
        rst          = r;
        clear        = cl;
        load         = ld;
        load_val     = 4'(lv);
        count_enable = en;
        count_dir    = dir;
        rollover_val = 4'(rv);
        e.c    = 4'(ec);
        e.f    = ef;
        e.w    = 2'(ew);
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, e.c, e.f, e.w);
            end
        end
    end

    initial begin : stim
        #2 chk("rst_async_init", 4'd0, 1'b0, 2'd0);
        step(1, 0, 0, 0, 1, 1, 5, 0, 0, 0, "rst_hold0");
        step(1, 0, 0, 0, 1, 1, 5, 0, 0, 0, "rst_hold1");
        step(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, "rst_release_idle");

        step(0, 0, 0, 0, 1, 1, 5, 1, 0, 0, "up1");
        step(0, 0, 0, 0, 1, 1, 5, 2, 0, 0, "up2");
        step(0, 0, 0, 0, 1, 1, 5, 3, 0, 0, "up3");
        step(0, 0, 0, 0, 1, 1, 5, 4, 0, 0, "up4");
        step(0, 0, 0, 0, 1, 1, 5, 5, 1, 0, "up5_term");
        step(0, 0, 0, 0, 1, 1, 5, 1, 0, 1, "up_wrap");
        step(0, 0, 0, 0, 1, 1, 5, 2, 0, 1, "up2_again");

        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_mid_async", 4'd0, 1'b0, 2'd0);
        step(1, 0, 0, 0, 1, 1, 5, 0, 0, 0, "rst_mid_hold0");
        step(1, 0, 0, 0, 1, 1, 5, 0, 0, 0, "rst_mid_hold1");
        step(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, "rst_mid_idle");
        step(0, 0, 0, 0, 1, 1, 5, 1, 0, 0, "rst_mid_first");

        step(0, 0, 1, 3, 0, 0, 6, 3, 0, 0, "dn_load3");
        step(0, 0, 0, 0, 1, 0, 6, 2, 0, 0, "dn2");
        step(0, 0, 0, 0, 1, 0, 6, 1, 1, 0, "dn1_term");
        step(0, 0, 0, 0, 1, 0, 6, 6, 0, 1, "dn_wrap6");
        step(0, 0, 0, 0, 1, 0, 6, 5, 0, 1, "dn5");

        step(0, 1, 1, 9, 1, 0, 6, 0, 0, 0, "prio_clear");
        step(0, 0, 1, 9, 1, 0, 6, 9, 0, 0, "prio_load");

        step(0, 0, 1, 7, 0, 1, 8, 7, 0, 0, "bnd_load7");
        step(0, 0, 0, 0, 1, 1, 4, 1, 0, 1, "bnd_wrap_above");
        step(0, 0, 0, 0, 1, 1, 0, 1, 0, 1, "bnd_rv0_up");
        step(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, "bnd_rv0_dn");
        step(0, 0, 1, 4, 0, 0, 0, 4, 0, 1, "bnd_rv0_load");
        step(0, 0, 0, 0, 1, 0, 0, 4, 0, 1, "bnd_rv0_hold");

        step(0, 0, 1, 1, 0, 0, 6, 1, 1, 1, "load_term_dn");
        step(0, 0, 0, 0, 0, 1, 3, 1, 1, 1, "flag_no_rv_upd");
        step(0, 0, 1, 2, 0, 1, 3, 2, 0, 1, "load2_up");
        step(0, 0, 0, 0, 1, 1, 3, 3, 1, 1, "up_term3");
        step(0, 0, 0, 0, 0, 1, 3, 3, 1, 1, "hold_term");
        step(0, 0, 0, 0, 1, 0, 3, 2, 0, 1, "dir_change");

        step(0, 1, 0, 0, 0, 1, 5, 0, 0, 0, "clear1");
        step(0, 0, 1, 5, 0, 1, 5, 5, 1, 0, "load_term_up");
        step(0, 0, 0, 0, 1, 1, 5, 1, 0, 1, "up_wrap_eq");

        step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, "sat_clear");
        step(0, 0, 1, 1, 0, 1, 1, 1, 1, 0, "sat_load1");
        step(0, 0, 0, 0, 1, 1, 1, 1, 1, 1, "sat1");
        step(0, 0, 0, 0, 1, 0, 1, 1, 1, 2, "sat2");
        step(0, 0, 0, 0, 1, 1, 1, 1, 1, 3, "sat3");
        step(0, 0, 0, 0, 1, 0, 1, 1, 1, 3, "sat4");
        step(0, 0, 0, 0, 1, 1, 1, 1, 1, 3, "sat5");
        step(0, 0, 0, 0, 1, 0, 1, 1, 1, 3, "sat6");
        step(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, "sat_clear_after");

        @(negedge clk);
        count_enable = 1'b0;
        clear        = 1'b0;
        load         = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got pending=%0d want pending=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
